// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader: FSM encoding and size defaults.
package regfile_dump_reader_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int NUM_REGS_DEF = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        SEND = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4
    } dumpState_t;

endpackage

// File: rtl/regdump_csum.sv
// XOR accumulator over transmitted register words; used only when REGDUMP_CHECKSUM_EN is defined.
module regdump_csum
    import regfile_dump_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock_in,
    input  logic              res,
    input  logic              clear,
    input  logic              enable,
    input  logic [DATA_W-1:0] dataIn,
    output logic [DATA_W-1:0] csum
);

    always_ff @(posedge clock_in or negedge res) begin
        if (!res)
            csum <= '0;
        else if (clear)
            csum <= '0;
        else if (enable)
            csum <= csum ^ dataIn;
    end

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks a wrapping register range through a read port and streams index/value over valid/ready.
// Define REGDUMP_CHECKSUM_EN to append an XOR checksum word after the last register.
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF
) (
    input  logic              clock_in,
    input  logic              res,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    dumpState_t        state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] lastReg;
    logic [ADDR_W-1:0] idxInc;
    logic              handshake;
    logic              atLast;

    // The read port always points at the current index, so rd_data is ready in READ.
    assign rd_addr   = idx;
    assign handshake = out_valid & out_ready;
    assign atLast    = (idx == lastReg);
    assign idxInc    = (idx == ADDR_W'(NUM_REGS - 1)) ? '0 : idx + ADDR_W'(1);

`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum;

    regdump_csum #(.DATA_W(DATA_W)) uCsum (
        .clock_in (clock_in),
        .res      (res),
        .clear    (state == IDLE && start && !abort),
        .enable   (state == SEND && handshake),
        .dataIn   (out_data),
        .csum     (csum)
    );
`endif

    always_ff @(posedge clock_in or negedge res) begin
        if (!res) begin
            state     <= IDLE;
            idx       <= '0;
            lastReg   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (abort) begin
            // A handshake coinciding with abort still transfers its word, but no done follows.
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        lastReg <= last_reg;
                        idx     <= first_reg;
                        busy    <= 1'b1;
                        state   <= READ;
                    end
                end
                READ: begin
                    out_data  <= rd_data;
                    out_index <= idx;
`ifdef REGDUMP_CHECKSUM_EN
                    out_last  <= 1'b0;
`else
                    out_last  <= atLast;
`endif
                    out_valid <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (handshake) begin
                        if (atLast) begin
`ifdef REGDUMP_CHECKSUM_EN
                            // Accumulator folds this word on the same edge, so fold it here too.
                            out_data  <= csum ^ out_data;
                            out_index <= '0;
                            out_last  <= 1'b1;
                            state     <= CSUM;
`else
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
`endif
                        end else begin
                            idx       <= idxInc;
                            out_valid <= 1'b0;
                            state     <= READ;
                        end
                    end
                end
                CSUM: begin
                    if (handshake) begin
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: table of dump ranges plus abort and reset sequences.
module tb_regfile_dump_reader;

    localparam int NUM_REGS = 32;

`ifdef REGDUMP_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic        clock_in = 1'b0;
    logic        res = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b1;
    logic [4:0]  first_reg = '0;
    logic [4:0]  last_reg = '0;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        out_valid;
    logic [31:0] out_data;
    logic [4:0]  out_index;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [31:0] mem [NUM_REGS];
    int checks = 0;
    int failures = 0;

    always #5 clock_in = ~clock_in;
    assign rd_data = mem[rd_addr];

    regfile_dump_reader dut (
        .clock_in  (clock_in),
        .res       (res),
        .start     (start),
        .abort     (abort),
        .first_reg (first_reg),
        .last_reg  (last_reg),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        int          first;
        int          last;
        int          stallAt;
        int          stallLen;
        bit          csumRegs;
        int          expWords;
        logic [31:0] expCsum;
        string       name;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic loadMem(input bit csumRegs);
        for (int i = 0; i < NUM_REGS; i++) mem[i] = 32'(i) * 32'h11111111;
        if (csumRegs) begin
            mem[1] = 32'hA5A5A5A5;
            mem[2] = 32'h0F0F0F0F;
            mem[3] = 32'h12345678;
        end
    endtask

    // Starts a dump at a negedge and follows it to the done pulse, checking every word.
    task automatic runDump(input vec_t v);
        int          k = 0;
        int          stallCnt = 0;
        int          lastAcc = -10;
        int          cycles = 0;
        int          idx;
        int          total;
        bit          gotDone = 1'b0;
        logic [31:0] acc = '0;
        logic [37:0] held = '0;
        logic [37:0] cur;
        logic [37:0] exp;
        total = v.expWords + int'(CS);
        out_ready = 1'b1;
        first_reg = 5'(v.first);
        last_reg  = 5'(v.last);
        start = 1'b1;
        @(negedge clock_in);
        start = 1'b0;
        chk({v.name, " read cycle"}, {busy, out_valid, rd_addr}, {1'b1, 1'b0, 5'(v.first)});
        @(negedge clock_in);
        chk({v.name, " first valid"}, out_valid, 1'b1);
        while (!gotDone && cycles < 400) begin
            cur = {out_data, out_index, out_last};
            if (done) begin
                gotDone = 1'b1;
                chk({v.name, " done timing"}, {16'(cycles), 16'(k), busy, out_valid},
                    {16'(lastAcc + 1), 16'(total), 1'b1, 1'b0});
            end else if (out_valid) begin
                if (k == v.stallAt && stallCnt < v.stallLen) begin
                    out_ready = 1'b0;
                    if (stallCnt > 0) chk({v.name, " hold"}, cur, held);
                    held = cur;
                    stallCnt++;
                end else begin
                    out_ready = 1'b1;
                    if (k == v.stallAt) chk({v.name, " hold release"}, cur, held);
                    if (k < v.expWords) begin
                        idx = (v.first + k) % NUM_REGS;
                        exp = {mem[idx], 5'(idx), 1'((k == v.expWords - 1) && !CS)};
                        acc ^= mem[idx];
                    end else begin
                        exp = {(v.expCsum != 0) ? v.expCsum : acc, 5'd0, 1'b1};
                    end
                    chk({v.name, " word"}, cur, exp);
                    k++;
                    lastAcc = cycles;
                end
            end
            @(negedge clock_in);
            cycles++;
        end
        if (!gotDone) chk({v.name, " done timeout"}, 1'b0, 1'b1);
        else chk({v.name, " done pulse end"}, {done, busy}, 2'b00);
        out_ready = 1'b1;
    endtask

    initial begin
        vec_t tv [5];
        vec_t extra;
        int   k;
        int   cyc;
        bit   sawDone;

        tv[0] = '{0, 31, -1, 0, 1'b0, 32, 32'h0, "full"};
        tv[1] = '{30, 1, -1, 0, 1'b0, 4, 32'h0, "wrap"};
        tv[2] = '{7, 7, -1, 0, 1'b0, 1, 32'h0, "single"};
        tv[3] = '{0, 7, 3, 5, 1'b0, 8, 32'h0, "stall"};
        tv[4] = '{1, 3, -1, 0, 1'b1, 3, 32'hB89EFCD2, "csum"};

        loadMem(1'b0);
        repeat (2) @(negedge clock_in);
        chk("reset state", {rd_addr, out_valid, out_data, out_index, out_last, busy, done}, '0);
        res = 1'b1;
        @(negedge clock_in);

        foreach (tv[i]) begin
            loadMem(tv[i].csumRegs);
            runDump(tv[i]);
        end

        // Abort together with the handshake of word 4.
        loadMem(1'b0);
        first_reg = 5'd0;
        last_reg  = 5'd7;
        start = 1'b1;
        @(negedge clock_in);
        start = 1'b0;
        k = 0;
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clock_in);
            cyc++;
            if (out_valid) begin
                if (k == 4) break;
                k++;
            end
        end
        chk("abort word index", {out_valid, out_index}, {1'b1, 5'd4});
        abort = 1'b1;
        @(negedge clock_in);
        abort = 1'b0;
        chk("abort exit", {busy, out_valid, done}, 3'b000);
        sawDone = 1'b0;
        repeat (4) begin
            @(negedge clock_in);
            sawDone |= done | busy;
        end
        chk("abort no done", sawDone, 1'b0);

        start = 1'b1;
        abort = 1'b1;
        @(negedge clock_in);
        start = 1'b0;
        abort = 1'b0;
        chk("abort beats start", {busy, out_valid}, 2'b00);
        extra = '{2, 4, -1, 0, 1'b0, 3, 32'h0, "after abort"};
        runDump(extra);

        // Asynchronous reset between edges in the middle of a dump.
        first_reg = 5'd5;
        last_reg  = 5'd20;
        start = 1'b1;
        @(negedge clock_in);
        start = 1'b0;
        repeat (6) @(negedge clock_in);
        #2 res = 1'b0;
        #1 chk("async reset", {rd_addr, out_valid, out_data, out_index, out_last, busy, done}, '0);
        @(negedge clock_in);
        res = 1'b1;
        @(negedge clock_in);
        extra = '{5, 6, -1, 0, 1'b0, 2, 32'h0, "after reset"};
        runDump(extra);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
